// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index, data word and writeback payload.
package cpu_types_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned WORD_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]    word_t;

    // One regfile write: destination index plus data.
    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: fixed priority for the in-order pipe, with a
// starvation counter that forces the long-latency unit through.
//   clk, rst       : clock, async active-high reset
//   pipe_valid     : in-order writeback present
//   long_valid     : long-unit result present
//   pipe_hold      : starvation limit reached; pipe (incl. WB) holds this cycle
//   long_ready     : long result may be accepted this cycle
//   pipe_grant     : pipe owns the write port this cycle
//   long_accept    : long result accepted this cycle
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pipe_valid,
    input  logic long_valid,
    output logic pipe_hold,
    output logic long_ready,
    output logic pipe_grant,
    output logic long_accept
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_cnt_n;

    // Decoded from registered state, so stable from the start of the cycle.
    assign pipe_hold   = (starve_cnt == SW'(STARVE_LIMIT));
    assign long_ready  = pipe_hold | ~pipe_valid;
    assign pipe_grant  = pipe_valid & ~pipe_hold;
    assign long_accept = long_valid & long_ready;

    // Count consecutive denied cycles; any accept or idle cycle clears it.
    always_comb begin
        starve_cnt_n = '0;
        if (long_valid && !long_ready) begin
            if (starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt_n = starve_cnt + SW'(1);
            else
                starve_cnt_n = starve_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_cnt_n;
    end

endmodule

// File: rtl/id_wb_scoreboard.sv
// Decode-stage register scoreboard and regfile write-port scheduler.
// Tracks destinations owned by in-flight long-latency ops, stalls decode on
// RAW/WAW hazards or a full long unit, and muxes pipe/long writebacks onto
// the single regfile write port.
//   clk, rst                          : clock, async active-high reset
//   issue_valid/rs1/rs2/rd/long       : decode instruction
//   issue_stall                       : decode must hold
//   pipe_wb_valid/rd/data             : in-order writeback (no ready)
//   pipe_hold                         : whole pipe holds this cycle
//   long_wb_valid/rd/data, long_wb_ready : long-unit result handshake
//   rf_load/rf_dest/rf_in             : regfile write port
//   busy                              : scoreboard bits (debug)
module id_wb_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  reg_idx_t            issue_rs1,
    input  reg_idx_t            issue_rs2,
    input  reg_idx_t            issue_rd,
    input  logic                issue_long,
    output logic                issue_stall,
    input  logic                pipe_wb_valid,
    input  reg_idx_t            pipe_wb_rd,
    input  word_t               pipe_wb_data,
    output logic                pipe_hold,
    input  logic                long_wb_valid,
    input  reg_idx_t            long_wb_rd,
    input  word_t               long_wb_data,
    output logic                long_wb_ready,
    output logic                rf_load,
    output reg_idx_t            rf_dest,
    output word_t               rf_in,
    output logic [NUM_REGS-1:0] busy
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [OW-1:0]       out_cnt;
    logic [OW-1:0]       out_cnt_n;
    logic [NUM_REGS-1:0] busy_n;
    logic                hazard;
    logic                issue_acc_long;
    logic                pipe_grant;
    logic                long_accept;
    wb_req_t             wb_sel;

    wb_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .pipe_valid  (pipe_wb_valid),
        .long_valid  (long_wb_valid),
        .pipe_hold   (pipe_hold),
        .long_ready  (long_wb_ready),
        .pipe_grant  (pipe_grant),
        .long_accept (long_accept)
    );

    // RAW on either source, WAW on destination, or long unit full. x0 never hazards.
    always_comb begin
        hazard = 1'b0;
        if (issue_valid) begin
            if (issue_rs1 != '0 && busy[issue_rs1]) hazard = 1'b1;
            if (issue_rs2 != '0 && busy[issue_rs2]) hazard = 1'b1;
            if (issue_rd  != '0 && busy[issue_rd])  hazard = 1'b1;
            if (issue_long && out_cnt == OW'(MAX_OUTSTANDING)) hazard = 1'b1;
        end
    end

    assign issue_stall    = hazard | pipe_hold;
    assign issue_acc_long = issue_valid & ~issue_stall & issue_long;

    // Write-port mux; writes to x0 are suppressed.
    always_comb begin
        wb_sel  = '0;
        rf_load = 1'b0;
        if (pipe_grant) begin
            wb_sel  = '{rd: pipe_wb_rd, data: pipe_wb_data};
            rf_load = (pipe_wb_rd != '0);
        end else if (long_accept) begin
            wb_sel  = '{rd: long_wb_rd, data: long_wb_data};
            rf_load = (long_wb_rd != '0);
        end
        rf_dest = wb_sel.rd;
        rf_in   = wb_sel.data;
    end

    // Clear on retire before set on issue; WAW stalls prevent a same-index collision.
    always_comb begin
        busy_n = busy;
        if (long_accept && long_wb_rd != '0)
            busy_n[long_wb_rd] = 1'b0;
        if (issue_acc_long && issue_rd != '0)
            busy_n[issue_rd] = 1'b1;
    end

    always_comb begin
        out_cnt_n = out_cnt;
        case ({issue_acc_long, long_accept})
            2'b10:   out_cnt_n = out_cnt + OW'(1);
            2'b01:   out_cnt_n = out_cnt - OW'(1);
            default: out_cnt_n = out_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            out_cnt <= '0;
        end else begin
            busy    <= busy_n;
            out_cnt <= out_cnt_n;
        end
    end

    // A retire with nothing outstanding is a long-unit protocol error.
    always @(posedge clk) begin
        if (!rst)
            assert (!(long_accept && !issue_acc_long && out_cnt == '0))
                else $error("id_wb_scoreboard: out_cnt underflow");
    end

endmodule

// File: tb/tb_id_wb_scoreboard.sv
// Scoreboard bench: stimulus pushes expected regfile writes; a monitor pops
// and compares them whenever rf_load is seen.
module tb_id_wb_scoreboard;
    import cpu_types_pkg::*;

    logic                clk;
    logic                rst;
    logic                issue_valid;
    reg_idx_t            issue_rs1, issue_rs2, issue_rd;
    logic                issue_long;
    logic                issue_stall;
    logic                pipe_wb_valid;
    reg_idx_t            pipe_wb_rd;
    word_t               pipe_wb_data;
    logic                pipe_hold;
    logic                long_wb_valid;
    reg_idx_t            long_wb_rd;
    word_t               long_wb_data;
    logic                long_wb_ready;
    logic                rf_load;
    reg_idx_t            rf_dest;
    word_t               rf_in;
    logic [NUM_REGS-1:0] busy;

    int n_chk  = 0;
    int n_pass = 0;
    wb_req_t exp_q[$];

    id_wb_scoreboard #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_long    (issue_long),
        .issue_stall   (issue_stall),
        .pipe_wb_valid (pipe_wb_valid),
        .pipe_wb_rd    (pipe_wb_rd),
        .pipe_wb_data  (pipe_wb_data),
        .pipe_hold     (pipe_hold),
        .long_wb_valid (long_wb_valid),
        .long_wb_rd    (long_wb_rd),
        .long_wb_data  (long_wb_data),
        .long_wb_ready (long_wb_ready),
        .rf_load       (rf_load),
        .rf_dest       (rf_dest),
        .rf_in         (rf_in),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_long = 0;
        pipe_wb_valid = 0; pipe_wb_rd = '0; pipe_wb_data = '0;
        long_wb_valid = 0; long_wb_rd = '0; long_wb_data = '0;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input logic lng);
        issue_valid = 1; issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2);
        issue_rd = 5'(rd); issue_long = lng;
    endtask

    task automatic pipe_wb(input int rd, input word_t d);
        pipe_wb_valid = 1; pipe_wb_rd = 5'(rd); pipe_wb_data = d;
    endtask

    task automatic long_wb(input int rd, input word_t d);
        long_wb_valid = 1; long_wb_rd = 5'(rd); long_wb_data = d;
    endtask

    task automatic expect_wr(input int rd, input word_t d);
        exp_q.push_back('{rd: 5'(rd), data: d});
    endtask

    task automatic to_check();
        @(negedge clk); #1;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_load) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL rf_write: unexpected write rd=%0d data=%0h", rf_dest, rf_in);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if (rf_dest === e.rd && rf_in === e.data) n_pass++;
                else $display("FAIL rf_write: got rd=%0d data=%0h expected rd=%0d data=%0h",
                              rf_dest, rf_in, e.rd, e.data);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check("rst_busy", busy, 32'h0);
        check("rst_hold", 32'(pipe_hold), 32'h0);
        check("rst_stall", 32'(issue_stall), 32'h0);
        check("rst_rf_load", 32'(rf_load), 32'h0);
        check("rst_ready", 32'(long_wb_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // RAW on x5 held until the cycle after its long writeback is accepted.
        issue(0, 0, 5, 1);
        to_check(); check("t1_issue_stall", 32'(issue_stall), 32'h0);
        next();
        issue(5, 0, 6, 0);
        to_check(); check("t1_raw_stall", 32'(issue_stall), 32'h1);
        check("t1_busy", busy, 32'h20);
        next();
        long_wb(5, 32'hAAAA_0005); expect_wr(5, 32'hAAAA_0005);
        to_check(); check("t1_stall_on_accept", 32'(issue_stall), 32'h1);
        check("t1_ready", 32'(long_wb_ready), 32'h1);
        check("t1_rf_dest", 32'(rf_dest), 32'h5);
        next();
        long_wb_valid = 0;
        to_check(); check("t1_unstall", 32'(issue_stall), 32'h0);
        check("t1_busy_clr", busy, 32'h0);
        next();
        idle();

        // Long op to x0: counted but never marks busy, and writes nothing.
        issue(0, 0, 0, 1);
        to_check(); check("t2_stall", 32'(issue_stall), 32'h0);
        next();
        idle();
        check("t2_busy", busy, 32'h0);
        check("t2_out_cnt", 32'(dut.out_cnt), 32'h1);
        long_wb(0, 32'h1234_5678);
        to_check(); check("t2_rf_load", 32'(rf_load), 32'h0);
        check("t2_ready", 32'(long_wb_ready), 32'h1);
        next();
        idle();
        check("t2_out_cnt_ret", 32'(dut.out_cnt), 32'h0);

        // Fill the long unit with x1..x4; fifth long stalls, short op does not.
        for (int i = 1; i <= 4; i++) begin
            issue(0, 0, i, 1);
            to_check(); check($sformatf("t3_fill%0d", i), 32'(issue_stall), 32'h0);
            next();
        end
        issue(0, 0, 10, 1);
        to_check(); check("t3_full_stall", 32'(issue_stall), 32'h1);
        check("t3_out_cnt", 32'(dut.out_cnt), 32'h4);
        issue(0, 0, 9, 0);
        to_check(); check("t3_short_ok", 32'(issue_stall), 32'h0);
        next();
        idle();
        check("t3_busy", busy, 32'h1E);

        // Starvation: three denied cycles, then the long unit is forced through.
        for (int c = 0; c < 3; c++) begin
            pipe_wb(12, 32'h5000_000C + 32'(c)); expect_wr(12, 32'h5000_000C + 32'(c));
            long_wb(1, 32'h1111_0001);
            to_check(); check($sformatf("t4_denied%0d", c), 32'(long_wb_ready), 32'h0);
            check($sformatf("t4_nohold%0d", c), 32'(pipe_hold), 32'h0);
            next();
        end
        expect_wr(1, 32'h1111_0001);
        to_check(); check("t4_hold", 32'(pipe_hold), 32'h1);
        check("t4_ready", 32'(long_wb_ready), 32'h1);
        check("t4_rf_in", rf_in, 32'h1111_0001);
        check("t4_stall", 32'(issue_stall), 32'h1);
        next();
        idle();
        to_check(); check("t4_hold_release", 32'(pipe_hold), 32'h0);
        check("t4_busy", busy, 32'h1C);
        check("t4_out_cnt", 32'(dut.out_cnt), 32'h3);
        next();

        // Same-cycle long issue to x7 and retire of x3.
        issue(0, 0, 7, 1);
        long_wb(3, 32'h3333_0003); expect_wr(3, 32'h3333_0003);
        to_check(); check("t5_stall", 32'(issue_stall), 32'h0);
        next();
        idle();
        to_check(); check("t5_busy", busy, 32'h94);
        check("t5_out_cnt", 32'(dut.out_cnt), 32'h3);
        next();
        long_wb(4, 32'h4444_0004); expect_wr(4, 32'h4444_0004);
        next();
        idle();
        check("t6_busy_pre", busy, 32'h84);
        check("t6_out_cnt_pre", 32'(dut.out_cnt), 32'h2);

        // Build up to pipe_hold, then reset asynchronously mid-cycle.
        for (int c = 0; c < 3; c++) begin
            pipe_wb(13, 32'h6000_000D + 32'(c)); expect_wr(13, 32'h6000_000D + 32'(c));
            long_wb(7, 32'h7777_0007);
            to_check();
            next();
        end
        check("t6_hold_before_rst", 32'(pipe_hold), 32'h1);
        idle();
        #1 rst = 1'b1;
        #1;
        check("t6_async_busy", busy, 32'h0);
        check("t6_async_out_cnt", 32'(dut.out_cnt), 32'h0);
        check("t6_async_hold", 32'(pipe_hold), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        to_check();
        check("t6_rel_stall", 32'(issue_stall), 32'h0);
        check("t6_rel_rf_load", 32'(rf_load), 32'h0);
        check("t6_rel_ready", 32'(long_wb_ready), 32'h1);
        check("t6_rel_busy", busy, 32'h0);
        next();
        next();
        check("all_writes_seen", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_wb_scoreboard.md
# id_wb_scoreboard

Register-writeback scheduler for the decode-stage register file. It tracks destination registers owned by in-flight long-latency ops (mul/div, miss loads) and stalls decode on RAW/WAW hazards against them. It arbitrates the single regfile write port between the in-order pipe writeback and the long-latency unit, with a starvation guard. It sits between decode/issue, writeback and the regfile write port (`load`/`dest`/`in`).

## Interface
Parameters:
- `MAX_OUTSTANDING`, 4: maximum in-flight long-latency ops.
- `STARVE_LIMIT`, 3: consecutive denied cycles before the long unit is forced through.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `issue_valid` in 1: decode presents an instruction.
- `issue_rs1`, `issue_rs2`, `issue_rd` in 5 each: source and destination indices.
- `issue_long` in 1: instruction goes to the long-latency unit.
- `issue_stall` out 1: decode must hold.
- `pipe_wb_valid`, `pipe_wb_rd`, `pipe_wb_data` in 1/5/32: in-order writeback. Has no ready; the pipe obeys `pipe_hold`.
- `pipe_hold` out 1: the whole pipe, including WB, holds this cycle.
- `long_wb_valid`, `long_wb_rd`, `long_wb_data` in 1/5/32: long-unit result.
- `long_wb_ready` out 1: long result accepted when valid & ready.
- `rf_load`, `rf_dest`, `rf_in` out 1/5/32: regfile write port.
- `busy` out 32: scoreboard bits, debug.

## Operation
- State: `busy[31:0]`, `out_cnt` (clog2(MAX_OUTSTANDING+1) bits), `starve_cnt` (clog2(STARVE_LIMIT+1) bits). All are zero on reset. Reset mid-operation discards all tracking; the long unit must be reset by the same `rst`.
- `hazard` = `issue_valid` & any of:
  - (`rs1`≠0 & `busy[rs1]`)
  - (`rs2`≠0 & `busy[rs2]`)
  - (`rd`≠0 & `busy[rd]`)
  - (`issue_long` & `out_cnt`==MAX_OUTSTANDING)
- `issue_stall` = `hazard` | `pipe_hold`. Issue is accepted when `issue_valid` & !`issue_stall`.
- `pipe_hold` = (`starve_cnt` == STARVE_LIMIT). It is decoded from registered state, so it is glitch-free at cycle start.
- Write-port grant:
  - If `pipe_hold`: long wins, `long_wb_ready`=1.
  - Otherwise: `long_wb_ready` = !`pipe_wb_valid`. The pipe has fixed priority.
- rf outputs:
  - Pipe granted (`pipe_wb_valid` & !`pipe_hold`): drive the pipe fields.
  - Long accepted: drive the long fields.
  - Otherwise: `rf_load`=0.
  - `rf_load` is forced 0 when the chosen rd==0.
- Accepted long issue with `rd`≠0 sets `busy[rd]`. `out_cnt`++ on every accepted long issue, including rd==0.
- Long wb accept clears `busy[long_wb_rd]` (no-op for x0) and decrements `out_cnt`.
- Same-cycle issue and retire: `out_cnt` is unchanged. Clear is applied before set, but same-index collision cannot occur because WAW stalls.
- `starve_cnt`:
  - Increments when `long_wb_valid` & !`long_wb_ready`.
  - Resets to 0 on long accept or when `long_wb_valid`=0.
  - Saturates at STARVE_LIMIT.
- Long wb with `busy[rd]`=0 (protocol error) still writes and decrements. Decrement below 0 is an assertion failure in simulation.

## Timing
- Hazard/stall, grant, `long_wb_ready` and rf outputs are combinational: a zero-cycle path to the regfile write.
- `busy`, `out_cnt` and `starve_cnt` update at the clock edge. A retiring register un-stalls decode the cycle after the long accept. The regfile bypass covers the same-cycle operand read.
- A long op issued in cycle N stalls dependents from cycle N+1.
- Starvation: long valid and denied for STARVE_LIMIT consecutive cycles → `pipe_hold` high the next cycle → long granted that cycle → `pipe_hold` low after.
- Reset-released outputs: `issue_stall` = `hazard` only (0 with idle inputs), `pipe_hold`=0, `rf_load`=0, `busy`=0, `long_wb_ready`=!`pipe_wb_valid`.

## Structure
- Package `cpu_types_pkg` (shared) holds `reg_idx_t` (logic [4:0]), `word_t` (logic [31:0]) and `NUM_REGS`=32.
- One natural sub-module is `wb_port_arbiter`: two-source fixed-priority grant plus the starvation counter. The scoreboard bits and `out_cnt` stay in the top.

## Test plan
- Issue long to x5, then an `add` reading x5 next cycle → `issue_stall`=1 until the cycle after long wb of x5 is accepted; `rf_dest`=5 on the accept cycle.
- Long op with rd=x0 → `busy` stays 0 and `out_cnt` goes 0→1→0; `rf_load`=0 at writeback.
- Issue 4 long ops to x1–x4 with MAX_OUTSTANDING=4, then a fifth long op → stall; a non-long op to x9 is not stalled.
- `pipe_wb_valid` held 1 and `long_wb_valid`=1 for 3 cycles → `long_wb_ready`=0 ×3, then `pipe_hold`=1 and `long_wb_ready`=1 on cycle 4, and `rf_in`=`long_wb_data`.
- Same cycle: long issue to x7 and long wb retiring x3 → `busy[7]`=1, `busy[3]`=0, `out_cnt` unchanged.
- Assert `rst` asynchronously with 2 ops outstanding → `busy`=0, `out_cnt`=0 and `pipe_hold`=0 immediately, without waiting for a clock edge.
